// File: rtl/gearbox_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_pkg
// Shared helpers for the DDR write-side gearbox FIFO.
//   clog2()   : constant ceil(log2) for deriving index widths from parameters.
//   IN_WIDTH_DEF/RATIO_DEF/DEPTH_WIDTH_DEF : default configuration.
//   OUT_WIDTH/LANE_W/CNT_W : widths derived from the defaults; modules derive
//                            their own from their actual parameters.
//   lane_t    : lane index type for the default configuration.
// -----------------------------------------------------------------------------
package gearbox_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int IN_WIDTH_DEF    = 32;
  localparam int RATIO_DEF       = 8;
  localparam int DEPTH_WIDTH_DEF = 6;

  localparam int OUT_WIDTH = IN_WIDTH_DEF * RATIO_DEF;
  localparam int LANE_W    = clog2(RATIO_DEF);
  localparam int CNT_W     = DEPTH_WIDTH_DEF + 1;

  typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/gearbox_packer.sv
// -----------------------------------------------------------------------------
// gearbox_packer
// Packs RATIO narrow words into one wide word, little-endian (lane k holds
// bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH]).
// Optional feature macro: GEARBOX_FLUSH_EN (zero-pad and commit a partial word).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : (GEARBOX_FLUSH_EN) request to commit a partial word
//   room_i         : (GEARBOX_FLUSH_EN) buffer can take a word this cycle
//   flush_ack_o    : (GEARBOX_FLUSH_EN) registered pulse, flush performed
//   wr_i           : narrow write accepted this cycle (already gated by full)
//   wr_data_i      : narrow write data
//   lane_o         : current lane index (next lane to be written)
//   word_o         : wide word to commit (valid when commit_o is high)
//   commit_o       : a complete wide word is committed on this clock edge
// -----------------------------------------------------------------------------
module gearbox_packer
  import gearbox_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 8,
  parameter int LANE_BITS = clog2(RATIO)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef GEARBOX_FLUSH_EN
  input  logic                      flush_i,
  input  logic                      room_i,
  output logic                      flush_ack_o,
`endif
  input  logic                      wr_i,
  input  logic [IN_WIDTH-1:0]       wr_data_i,
  output logic [LANE_BITS-1:0]      lane_o,
  output logic [IN_WIDTH*RATIO-1:0] word_o,
  output logic                      commit_o
);

  localparam int WIDE_W = IN_WIDTH * RATIO;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(RATIO - 1);

  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [WIDE_W-1:0]    pack_q, pack_d;
  logic                 commit;
`ifdef GEARBOX_FLUSH_EN
  logic                 ack_q, ack_d;
`endif

  // pack_d is the register's next value and also the word handed to the
  // buffer, so a commit stores the word including the lane written this cycle.
  always_comb begin
    pack_d = pack_q;
    lane_d = lane_q;
    commit = 1'b0;
`ifdef GEARBOX_FLUSH_EN
    ack_d  = 1'b0;
`endif
    if (wr_i) begin
      for (int k = 0; k < RATIO; k++) begin
        if (lane_q == LANE_BITS'(k)) pack_d[k*IN_WIDTH +: IN_WIDTH] = wr_data_i;
      end
      lane_d = lane_q + LANE_BITS'(1);
      commit = (lane_q == LAST_LANE);
    end
`ifdef GEARBOX_FLUSH_EN
    // The write (if any) lands first; a flush then pads whatever is still
    // unfilled. If the write already completed the word, the normal commit
    // stands and is acknowledged as the flush.
    if (flush_i && room_i) begin
      if (!commit && (lane_d != '0)) begin
        for (int k = 0; k < RATIO; k++) begin
          if (LANE_BITS'(k) >= lane_d) pack_d[k*IN_WIDTH +: IN_WIDTH] = '0;
        end
        lane_d = '0;
        commit = 1'b1;
      end
      ack_d = commit;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
`ifdef GEARBOX_FLUSH_EN
      ack_q  <= 1'b0;
`endif
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
`ifdef GEARBOX_FLUSH_EN
      ack_q  <= ack_d;
`endif
    end
  end

  assign lane_o   = lane_q;
  assign word_o   = pack_d;
  assign commit_o = commit;
`ifdef GEARBOX_FLUSH_EN
  assign flush_ack_o = ack_q;
`endif

endmodule

// File: rtl/ddr_wr_gearbox_fifo.sv
// -----------------------------------------------------------------------------
// ddr_wr_gearbox_fifo
// Single-clock write-side FIFO for the DDR write path: packs RATIO narrow
// words into one wide word and buffers 2^DEPTH_WIDTH wide words.
// Optional feature macro: GEARBOX_FLUSH_EN (adds flush / flush_ack).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : (GEARBOX_FLUSH_EN) zero-pad and commit a partial word
//   flush_ack       : (GEARBOX_FLUSH_EN) one-cycle pulse, flush performed
//   wr_en, wr_data  : narrow write
//   wr_full         : next narrow write would be refused
//   almost_full     : entry count >= ALMOST_FULL_NUM
//   wr_water_level  : narrow words held (count*RATIO + lane)
//   rd_en, rd_data  : wide read; rd_data valid the cycle after an accepted read
//   rd_empty        : no complete wide word buffered
//   almost_empty    : entry count <= ALMOST_EMPTY_NUM
//   rd_water_level  : complete wide words buffered
//   burst_rdy       : entry count >= BURST_LEN
//   wr_overflow     : one-cycle pulse, a write was refused
//   rd_underflow    : one-cycle pulse, a read was refused
//
// Handshake: a write is accepted on any edge where wr_en && !wr_full, and a
// read on any edge where rd_en && !rd_empty. Refused requests change no state
// and raise the matching error pulse in the following cycle. The flags are
// decoded from registered state only, so a same-cycle read never lifts
// wr_full.
// -----------------------------------------------------------------------------
module ddr_wr_gearbox_fifo
  import gearbox_pkg::*;
#(
  parameter int IN_WIDTH         = IN_WIDTH_DEF,
  parameter int RATIO            = RATIO_DEF,
  parameter int DEPTH_WIDTH      = DEPTH_WIDTH_DEF,
  parameter int ALMOST_FULL_NUM  = 60,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int BURST_LEN        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
`ifdef GEARBOX_FLUSH_EN
  input  logic                                 flush,
  output logic                                 flush_ack,
`endif
  input  logic                                 wr_en,
  input  logic [IN_WIDTH-1:0]                  wr_data,
  output logic                                 wr_full,
  output logic                                 almost_full,
  output logic [DEPTH_WIDTH+clog2(RATIO):0]    wr_water_level,
  input  logic                                 rd_en,
  output logic [IN_WIDTH*RATIO-1:0]            rd_data,
  output logic                                 rd_empty,
  output logic                                 almost_empty,
  output logic [DEPTH_WIDTH:0]                 rd_water_level,
  output logic                                 burst_rdy,
  output logic                                 wr_overflow,
  output logic                                 rd_underflow
);

  localparam int WIDE_W    = IN_WIDTH * RATIO;
  localparam int LANE_BITS = clog2(RATIO);
  localparam int CNT_BITS  = DEPTH_WIDTH + 1;
  localparam int ENTRIES   = 1 << DEPTH_WIDTH;

  localparam logic [CNT_BITS-1:0]  FULL_CNT  = CNT_BITS'(ENTRIES);
  localparam logic [CNT_BITS-1:0]  AF_CNT    = CNT_BITS'(ALMOST_FULL_NUM);
  localparam logic [CNT_BITS-1:0]  AE_CNT    = CNT_BITS'(ALMOST_EMPTY_NUM);
  localparam logic [CNT_BITS-1:0]  BURST_CNT = CNT_BITS'(BURST_LEN);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(RATIO - 1);

  logic [WIDE_W-1:0]      mem_q [ENTRIES];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]    count_q, count_d;
  logic [WIDE_W-1:0]      rd_data_q;
  logic                   ovf_q, udf_q;

  logic [LANE_BITS-1:0]   lane;
  logic [WIDE_W-1:0]      commit_word;
  logic                   commit;
  logic                   buf_full, buf_empty, wr_acc, rd_acc;

  assign buf_full  = (count_q == FULL_CNT);
  assign buf_empty = (count_q == '0);
  // Narrow writes may keep filling the pack register while the buffer is full;
  // only the write that would complete a word has nowhere to go.
  assign wr_full   = buf_full && (lane == LAST_LANE);
  assign wr_acc    = wr_en && !wr_full;
  assign rd_acc    = rd_en && !buf_empty;

  gearbox_packer #(
    .IN_WIDTH  (IN_WIDTH),
    .RATIO     (RATIO),
    .LANE_BITS (LANE_BITS)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef GEARBOX_FLUSH_EN
    .flush_i     (flush),
    .room_i      (!buf_full),
    .flush_ack_o (flush_ack),
`endif
    .wr_i        (wr_acc),
    .wr_data_i   (wr_data),
    .lane_o      (lane),
    .word_o      (commit_word),
    .commit_o    (commit)
  );

  always_comb begin
    count_d = count_q;
    if (commit && !rd_acc)      count_d = count_q + CNT_BITS'(1);
    else if (!commit && rd_acc) count_d = count_q - CNT_BITS'(1);
  end

  // Storage is not reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (commit) mem_q[wr_ptr_q] <= commit_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= wr_en && wr_full;
      udf_q   <= rd_en && buf_empty;
      if (commit) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      if (rd_acc) begin
        rd_ptr_q  <= rd_ptr_q + DEPTH_WIDTH'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_empty       = buf_empty;
  assign almost_full    = (count_q >= AF_CNT);
  assign almost_empty   = (count_q <= AE_CNT);
  assign burst_rdy      = (count_q >= BURST_CNT);
  assign rd_water_level = count_q;
  // RATIO is a power of two, so count*RATIO + lane is a concatenation.
  assign wr_water_level = {count_q, lane};
  assign wr_overflow    = ovf_q;
  assign rd_underflow   = udf_q;

endmodule

// File: tb/tb_ddr_wr_gearbox_fifo.sv
module tb_ddr_wr_gearbox_fifo;
  import gearbox_pkg::*;

  localparam int IW = 32;
  localparam int R  = 8;
  localparam int WW = IW * R;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [IW-1:0] wr_data = '0;
  logic          wr_full, almost_full, rd_empty, almost_empty, burst_rdy;
  logic          wr_overflow, rd_underflow;
  logic [9:0]    wr_water_level;
  logic [6:0]    rd_water_level;
  logic [WW-1:0] rd_data;
`ifdef GEARBOX_FLUSH_EN
  logic          flush = 1'b0;
  logic          flush_ack;
`endif

  ddr_wr_gearbox_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef GEARBOX_FLUSH_EN
    .flush          (flush),
    .flush_ack      (flush_ack),
`endif
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_full        (wr_full),
    .almost_full    (almost_full),
    .wr_water_level (wr_water_level),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .almost_empty   (almost_empty),
    .rd_water_level (rd_water_level),
    .burst_rdy      (burst_rdy),
    .wr_overflow    (wr_overflow),
    .rd_underflow   (rd_underflow)
  );

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] cur_word = '0;
  lane_t         cur_lane = '0;
  logic [WW-1:0] last_exp = '0;
  logic [WW-1:0] exp_w;

  localparam logic [WW-1:0] WORD0 =
    256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input logic [IW-1:0] d);
    cur_word[int'(cur_lane)*IW +: IW] = d;
    if (cur_lane == lane_t'(R - 1)) exp_q.push_back(cur_word);
    cur_lane = cur_lane + lane_t'(1);
  endtask

  task automatic push(input logic [IW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    model_accept(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pull();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    cur_word = '0;
    cur_lane = '0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got=%0b exp=1", rd_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%0b exp=1", almost_empty); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got=%0b exp=0", wr_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%0b exp=0", almost_full); end
    checks++; if (burst_rdy !== 1'b0) begin errors++; $display("FAIL reset_burst_rdy got=%0b exp=0", burst_rdy); end
    checks++; if (wr_water_level !== 10'd0) begin errors++; $display("FAIL reset_wr_level got=%0d exp=0", wr_water_level); end
    checks++; if (rd_water_level !== 7'd0) begin errors++; $display("FAIL reset_rd_level got=%0d exp=0", rd_water_level); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%0b%0b exp=00", wr_overflow, rd_underflow); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_word();
    do_reset();
    for (int k = 0; k < 7; k++) push(IW'(k));
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL first_partial_empty got=%0b exp=1", rd_empty); end
    checks++; if (wr_water_level !== 10'd7) begin errors++; $display("FAIL first_partial_level got=%0d exp=7", wr_water_level); end
    push(IW'(7));
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL first_commit_empty got=%0b exp=0", rd_empty); end
    checks++; if (rd_water_level !== 7'd1) begin errors++; $display("FAIL first_rd_level got=%0d exp=1", rd_water_level); end
    checks++; if (wr_water_level !== 10'd8) begin errors++; $display("FAIL first_wr_level got=%0d exp=8", wr_water_level); end
    pull();
    void'(exp_q.pop_front());
    checks++; if (rd_data !== WORD0) begin errors++; $display("FAIL first_rd_data got=%h exp=%h", rd_data, WORD0); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL first_drained_empty got=%0b exp=1", rd_empty); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < R; k++) push(IW'(i * 8 + k));
      if (i == 58) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at_59 got=%0b exp=0", almost_full); end
      end
      if (i == 59) begin
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_at_60 got=%0b exp=1", almost_full); end
      end
    end
    for (int k = 0; k < 7; k++) push(IW'(512 + k));
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0b exp=1", wr_full); end
    checks++; if (wr_water_level !== 10'd519) begin errors++; $display("FAIL full_wr_level got=%0d exp=519", wr_water_level); end
    checks++; if (rd_water_level !== 7'd64) begin errors++; $display("FAIL full_rd_level got=%0d exp=64", rd_water_level); end
    // refused write
    wr_en = 1'b1; wr_data = 32'hDEAD_DEAD;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%0b exp=1", wr_overflow); end
    checks++; if (wr_water_level !== 10'd519) begin errors++; $display("FAIL ovf_level got=%0d exp=519", wr_water_level); end
    tick();
    checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", wr_overflow); end
    // read in the same cycle does not lift wr_full
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hBEEF_BEEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL rdwr_ovf got=%0b exp=1", wr_overflow); end
    checks++; if (rd_water_level !== 7'd63) begin errors++; $display("FAIL rdwr_rd_level got=%0d exp=63", rd_water_level); end
    checks++; if (wr_water_level !== 10'd511) begin errors++; $display("FAIL rdwr_wr_level got=%0d exp=511", wr_water_level); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL rdwr_full got=%0b exp=0", wr_full); end
    checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL rdwr_data got=%h exp=%h", rd_data, exp_w); end
    push(IW'(519));
    checks++; if (wr_water_level !== 10'd512) begin errors++; $display("FAIL refill_level got=%0d exp=512", wr_water_level); end
    // drain, checking order, data and the almost_empty boundary
    for (int n = 64; n > 0; n--) begin
      pull();
      exp_w = exp_q.pop_front();
      checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL drain_data n=%0d got=%h exp=%h", n, rd_data, exp_w); end
      if (n == 6) begin
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL ae_at_5 got=%0b exp=0", almost_empty); end
      end
      if (n == 5) begin
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL ae_at_4 got=%0b exp=1", almost_empty); end
      end
    end
    last_exp = exp_w;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL drained_empty got=%0b exp=1", rd_empty); end
  endtask

  task automatic test_underflow();
    pull();
    checks++; if (rd_underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%0b exp=1", rd_underflow); end
    checks++; if (rd_data !== last_exp) begin errors++; $display("FAIL udf_hold got=%h exp=%h", rd_data, last_exp); end
    tick();
    checks++; if (rd_underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got=%0b exp=0", rd_underflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < R; k++) push(IW'(32'h1000 + i * 8 + k));
      if (i == 14) begin
        checks++; if (burst_rdy !== 1'b0) begin errors++; $display("FAIL burst_at_15 got=%0b exp=0", burst_rdy); end
      end
    end
    checks++; if (burst_rdy !== 1'b1) begin errors++; $display("FAIL burst_at_16 got=%0b exp=1", burst_rdy); end
    pull();
    exp_w = exp_q.pop_front();
    checks++; if (burst_rdy !== 1'b0) begin errors++; $display("FAIL burst_after_rd got=%0b exp=0", burst_rdy); end
    checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL b2b_first got=%h exp=%h", rd_data, exp_w); end
    for (int k = 0; k < 7; k++) push(IW'(32'h2000 + k));
    // commit and read on the same edge
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h2007;
    model_accept(32'h2007);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (rd_water_level !== 7'd15) begin errors++; $display("FAIL b2b_count got=%0d exp=15", rd_water_level); end
    checks++; if (wr_water_level !== 10'd120) begin errors++; $display("FAIL b2b_wr_level got=%0d exp=120", wr_water_level); end
    checks++; if (rd_data !== exp_w) begin errors++; $display("FAIL b2b_data got=%h exp=%h", rd_data, exp_w); end
    for (int k = 0; k < R; k++) push(IW'(32'h3000 + k));
    checks++; if (burst_rdy !== 1'b1) begin errors++; $display("FAIL burst_again got=%0b exp=1", burst_rdy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 11; k++) push(IW'(32'h4000 + k));
    rst_n = 1'b0;
    #1;
    checks++; if (rd_water_level !== 7'd0) begin errors++; $display("FAIL midrst_rd_level got=%0d exp=0", rd_water_level); end
    checks++; if (wr_water_level !== 10'd0) begin errors++; $display("FAIL midrst_wr_level got=%0d exp=0", wr_water_level); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
    do_reset();
    for (int k = 0; k < R; k++) push(IW'(k));
    checks++; if (wr_water_level !== 10'd8) begin errors++; $display("FAIL midrst_relevel got=%0d exp=8", wr_water_level); end
    pull();
    void'(exp_q.pop_front());
    checks++; if (rd_data !== WORD0) begin errors++; $display("FAIL midrst_data got=%h exp=%h", rd_data, WORD0); end
  endtask

`ifdef GEARBOX_FLUSH_EN
  task automatic test_flush();
    logic [WW-1:0] fw;
    fw = 256'h00000000_00000000_00000000_00000000_00000000_0000000C_0000000B_0000000A;
    do_reset();
    push(32'hA); push(32'hB); push(32'hC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cur_lane = '0;
    checks++; if (flush_ack !== 1'b1) begin errors++; $display("FAIL flush_ack got=%0b exp=1", flush_ack); end
    checks++; if (wr_water_level !== 10'd8) begin errors++; $display("FAIL flush_level got=%0d exp=8", wr_water_level); end
    pull();
    checks++; if (rd_data !== fw) begin errors++; $display("FAIL flush_data got=%h exp=%h", rd_data, fw); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL flush_lane0_ack got=%0b exp=0", flush_ack); end
    checks++; if (wr_water_level !== 10'd0) begin errors++; $display("FAIL flush_lane0_level got=%0d exp=0", wr_water_level); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
`ifdef GEARBOX_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
